// File: rtl/div_clk_5.sv
// -----------------------------------------------------------------------------
// div_clk_5 -- integer clock divider, clk_5 = f(clk)/DIV_N with 50% duty.
//
// Even ratios come straight from a rising-edge flop. Odd ratios OR that flop
// with a falling-edge copy of itself, which stretches the high phase by half a
// clk period so high and low phases both last DIV_N/2 clk periods.
//
// Parameters:
//   DIV_N        division ratio, integer >= 2 (odd or even)
//
// Ports:
//   clk          system clock (rising edge; falling edge for the odd helper)
//   rst          synchronous, active-high reset
//   clk_5        divided clock, reset value 0
//   clk_5_pulse  one-clk-cycle strobe coincident with each clk_5 rising edge
//                (only present when DIV_CLK_5_PULSE_EN is defined)
//
// Optional feature macro: DIV_CLK_5_PULSE_EN
// -----------------------------------------------------------------------------
module div_clk_5 #(
  parameter int DIV_N = 5
) (
  input  logic clk,
  input  logic rst,
`ifdef DIV_CLK_5_PULSE_EN
  output logic clk_5_pulse,
`endif
  output logic clk_5
);

  localparam int              CW   = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV_N - 1);
  // Integer division gives DIV_N/2 for even and (DIV_N-1)/2 for odd ratios.
  localparam logic [CW-1:0]   HALF = CW'(DIV_N / 2);
  localparam bit              ODD  = (DIV_N % 2) != 0;

  generate
    if (DIV_N < 2) begin : g_bad_div
      $error("div_clk_5: DIV_N must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          p_q;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // Reset parks the counter on its last value so the first released edge
  // lands on cnt=0 and raises clk_5 immediately: deterministic phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LAST;
      p_q <= 1'b0;
    end else begin
      cnt <= cnt_next;
      p_q <= (cnt_next < HALF);
    end
  end

  generate
    if (ODD) begin : g_odd
      logic n_q;

      // Half-cycle delayed copy of p_q; OR-ing it in extends the high phase
      // by half a clk period. Both terms overlap at every p_q transition,
      // so the OR cannot glitch.
      always_ff @(negedge clk) begin
        if (rst) begin
          n_q <= 1'b0;
        end else begin
          n_q <= p_q;
        end
      end

      assign clk_5 = p_q | n_q;
    end else begin : g_even
      assign clk_5 = p_q;
    end
  endgenerate

`ifdef DIV_CLK_5_PULSE_EN
  // Strobe for logic kept in the clk domain: high for the cnt=0 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_5_pulse <= 1'b0;
    end else begin
      clk_5_pulse <= (cnt_next == '0);
    end
  end
`endif

endmodule

// File: tb/tb_div_clk_5.sv
// -----------------------------------------------------------------------------
// tb_div_clk_5 -- self-checking bench for div_clk_5 with DIV_N = 5, 4, 2, 7.
// A reference model derives clk_5 (and clk_5_pulse when DIV_CLK_5_PULSE_EN is
// defined) from the number of clk rising edges seen since reset released,
// sampled 1 ns into each half of every clk period.
// -----------------------------------------------------------------------------
module tb_div_clk_5;

  logic clk;
  logic rst;
  logic c5, c4, c2, c7;
`ifdef DIV_CLK_5_PULSE_EN
  logic pl5, pl4, pl2, pl7;
`endif

  int checks = 0;
  int errors = 0;

  div_clk_5 #(.DIV_N(5)) dut5 (
    .clk(clk), .rst(rst),
`ifdef DIV_CLK_5_PULSE_EN
    .clk_5_pulse(pl5),
`endif
    .clk_5(c5));
  div_clk_5 #(.DIV_N(4)) dut4 (
    .clk(clk), .rst(rst),
`ifdef DIV_CLK_5_PULSE_EN
    .clk_5_pulse(pl4),
`endif
    .clk_5(c4));
  div_clk_5 #(.DIV_N(2)) dut2 (
    .clk(clk), .rst(rst),
`ifdef DIV_CLK_5_PULSE_EN
    .clk_5_pulse(pl2),
`endif
    .clk_5(c2));
  div_clk_5 #(.DIV_N(7)) dut7 (
    .clk(clk), .rst(rst),
`ifdef DIV_CLK_5_PULSE_EN
    .clk_5_pulse(pl7),
`endif
    .clk_5(c7));

  // Period 20 ns, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [3:0] outs;
  assign outs = {c7, c2, c4, c5};
`ifdef DIV_CLK_5_PULSE_EN
  logic [3:0] pulses;
  assign pulses = {pl7, pl2, pl4, pl5};
`endif
  int nv[4] = '{5, 4, 2, 7};

  // Reference model: m = rising edges with rst=0 since the last one with
  // rst=1. Position in the output period is (m-1) mod N; the output is high
  // for the first N/2 (rounded down) positions, and odd ratios stay high for
  // an extra half period unless a reset reached the falling edge first.
  initial begin
    int  m = 0;
    int  cyc = 0;
    bit  r;
    bit  rn_prev = 1'b1;
    bit  ep[4];
    bit  ep_prev[4] = '{0, 0, 0, 0};
    bit  ef;
    forever begin
      @(posedge clk);
      r = rst;
      cyc++;
      m = r ? 0 : m + 1;
      #1;
      for (int i = 0; i < 4; i++) begin
        ep[i] = !r && (((m - 1) % nv[i]) < (nv[i] / 2));
        ef = ep[i] | ((nv[i] % 2 == 1) && !rn_prev && ep_prev[i]);
        if (cyc >= 2) begin
          chk($sformatf("clk_5_n%0d_first_half", nv[i]), outs[i], ef);
`ifdef DIV_CLK_5_PULSE_EN
          chk($sformatf("pulse_n%0d_first_half", nv[i]), pulses[i],
              !r && (((m - 1) % nv[i]) == 0));
`endif
        end
      end
      @(negedge clk);
      rn_prev = rst;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (cyc >= 2) begin
          chk($sformatf("clk_5_n%0d_second_half", nv[i]), outs[i], ep[i]);
`ifdef DIV_CLK_5_PULSE_EN
          chk($sformatf("pulse_n%0d_second_half", nv[i]), pulses[i],
              !r && (((m - 1) % nv[i]) == 0));
`endif
        end
        ep_prev[i] = ep[i];
      end
    end
  end

  // No phase of the odd-ratio outputs may be shorter than half a clk period.
  time t5_last = 0;
  time t7_last = 0;
  always @(c5) begin
    if (t5_last != 0) chk("width_n5", ($time - t5_last) >= 10, 1);
    t5_last = $time;
  end
  always @(c7) begin
    if (t7_last != 0) chk("width_n7", ($time - t7_last) >= 10, 1);
    t7_last = $time;
  end

  // Absolute edge times of the DIV_N=5 output around the directed resets.
  time rise_a = 0;
  time fall_a = 0;
  time rise_b = 0;
  always @(posedge c5) begin
    if ($time > 115 && rise_a == 0) rise_a = $time;
    if ($time > 315 && rise_b == 0) rise_b = $time;
  end
  always @(negedge c5) begin
    if ($time > 115 && fall_a == 0) fall_a = $time;
  end

  initial begin
    int hold = 0;
    rst = 1'b1;
    #115 rst = 1'b0;
    #130 rst = 1'b1;  // t = 245, clk_5 high
    #70  rst = 1'b0;  // t = 315
    #100;             // t = 415
    chk("first_rise_time", rise_a, 130);
    chk("first_fall_time", fall_a, 180);
    chk("rise_after_midrun_reset", rise_b, 330);

    // Randomised reset bursts, changed just after rising edges.
    repeat (800) begin
      @(posedge clk);
      #2;
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        rst  = 1'b1;
        hold = $urandom_range(1, 4);
      end
    end
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
